// File: rtl/core_cfu_pkg.sv
// Shared encodings for the execute-stage control flow unit and its return-address stack.
package core_cfu_pkg;

  // writeback op encodings
  localparam int CFU_OP_W = 3;
  localparam logic [CFU_OP_W-1:0] CFU_OP_NOP    = 3'd0;
  localparam logic [CFU_OP_W-1:0] CFU_OP_TAKEN  = 3'd1;
  localparam logic [CFU_OP_W-1:0] CFU_OP_IGNORE = 3'd2;
  localparam logic [CFU_OP_W-1:0] CFU_OP_MRET   = 3'd3;
  localparam logic [CFU_OP_W-1:0] CFU_OP_TRAP   = 3'd4;

  // trap cause codes
  localparam logic [6:0] TRAP_IALIGN  = 7'd0;
  localparam logic [6:0] TRAP_IACCESS = 7'd1;
  localparam logic [6:0] TRAP_BREAKPT = 7'd3;
  localparam logic [6:0] TRAP_ECALLM  = 7'd11;

  // cfu_op one-hot bit positions
  localparam int CFU_OP_N  = 12;
  localparam int OP_BEQ    = 0;
  localparam int OP_BNE    = 1;
  localparam int OP_BLT    = 2;
  localparam int OP_BGE    = 3;
  localparam int OP_BLTU   = 4;
  localparam int OP_BGEU   = 5;
  localparam int OP_J      = 6;
  localparam int OP_JAL    = 7;
  localparam int OP_JALR   = 8;
  localparam int OP_MRET   = 9;
  localparam int OP_EBRK   = 10;
  localparam int OP_ECALL  = 11;

  // link registers for call/return detection
  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } cfu_state_t;

  function automatic logic is_link(input logic [4:0] idx);
    return (idx == LINK_X1) || (idx == LINK_X5);
  endfunction

endpackage

// File: rtl/core_cfu_ras.sv
// Circular return-address stack: push, pop, and pop-then-push (replace top).
// A push at full overwrites the oldest entry; a pop at empty is ignored.
module core_cfu_ras #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] top_idx;

  assign top_idx = ptr - PTR_W'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);

  // pointer and occupancy; pop-push on a non-empty stack leaves both unchanged
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && !(pop && !empty)) begin
      ptr <= ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
    end else if (pop && !push && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // entry storage; replace-top writes the current top slot
  always_ff @(posedge g_clk) begin
    if (!g_reset && push) begin
      if (pop && !empty) mem[top_idx] <= push_data;
      else               mem[ptr]     <= push_data;
    end
  end

endmodule

// File: rtl/core_pipe_exec_cfu_ras.sv
// Execute-stage control flow unit: resolves branches/jumps/mret/ecall/ebreak,
// issues control-flow change requests through a small FSM, and predicts
// jalr returns with a return-address stack.
//
// state | meaning
// IDLE  | evaluating the current instruction, request asserted combinationally
// REQ   | request outstanding, target held until cf_ack
// DONE  | request accepted, waiting for the next instruction
module core_pipe_exec_cfu_ras
  import core_cfu_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int PADDR_W   = 39,
  parameter int IALIGN    = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic                g_clk,
  input  logic                g_reset,
  input  logic                new_instr,
  input  logic                valid,
  input  logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     npc,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     offset,
  input  logic [4:0]          rd_addr,
  input  logic [4:0]          rs1_addr,
  input  logic                cmp_eq,
  input  logic                cmp_lt,
  input  logic                cmp_ltu,
  input  logic [CFU_OP_N-1:0] cfu_op,
  input  logic [XLEN-1:0]     csr_mepc,
  output logic                cf_valid,
  input  logic                cf_ack,
  output logic [XLEN-1:0]     cf_target,
  output logic [XLEN-1:0]     new_pc,
  output logic [CFU_OP_W-1:0] new_op,
  output logic [XLEN-1:0]     rd_wdata,
  output logic                rd_wen,
  output logic                trap_raise,
  output logic [6:0]          trap_cause,
  output logic                finished,
  output logic                ras_pred_valid,
  output logic [XLEN-1:0]     ras_pred_target,
  output logic                ras_mispredict
);

  // address bits above the implemented physical range; empty when PADDR_W == XLEN
  localparam logic [XLEN-1:0] HI_MASK = (PADDR_W >= XLEN) ? '0 : ({XLEN{1'b1}} << PADDR_W);

  cfu_state_t      state_q, state_d;
  logic [XLEN-1:0] target_q;
  logic            armed_q;

  logic            is_cond, cond_true, taken, req, ack_hit;
  logic [XLEN-1:0] sum, target, dest;
  logic            nonexist, misalign;
  logic            link_rd, link_rs1, do_push, do_pop, commit;
  logic            ras_empty;

  assign is_cond   = |cfu_op[OP_BGEU:OP_BEQ];
  assign cond_true = (cfu_op[OP_BEQ]  &  cmp_eq)  | (cfu_op[OP_BNE]  & ~cmp_eq)  |
                     (cfu_op[OP_BLT]  &  cmp_lt)  | (cfu_op[OP_BGE]  & ~cmp_lt)  |
                     (cfu_op[OP_BLTU] &  cmp_ltu) | (cfu_op[OP_BGEU] & ~cmp_ltu);
  assign taken     = cond_true | cfu_op[OP_J] | cfu_op[OP_JAL] | cfu_op[OP_JALR] | cfu_op[OP_MRET];

  assign sum      = (cfu_op[OP_JALR] ? rs1 : pc) + offset;
  assign target   = cfu_op[OP_JALR] ? {sum[XLEN-1:1], 1'b0} : sum;
  assign dest     = cfu_op[OP_MRET] ? csr_mepc : target;
  assign nonexist = |(dest & HI_MASK);
  assign misalign = (IALIGN == 4) ? |dest[1:0] : dest[0];

  assign trap_raise = valid & (cfu_op[OP_ECALL] | cfu_op[OP_EBRK] | (taken & (nonexist | misalign)));
  assign req        = valid & taken & ~trap_raise;

  // trap cause priority: access fault, ecall, ebreak, then misalignment
  always_comb begin
    trap_cause = TRAP_IALIGN;
    if (taken && nonexist)    trap_cause = TRAP_IACCESS;
    else if (cfu_op[OP_ECALL]) trap_cause = TRAP_ECALLM;
    else if (cfu_op[OP_EBRK])  trap_cause = TRAP_BREAKPT;
  end

  // request FSM next state and outputs; a new instruction in DONE is evaluated as from IDLE
  always_comb begin
    state_d   = state_q;
    cf_valid  = 1'b0;
    cf_target = dest;
    if (state_q == ST_REQ) begin
      cf_valid  = 1'b1;
      cf_target = target_q;
      if (new_instr)   state_d = ST_IDLE;
      else if (cf_ack) state_d = ST_DONE;
    end else if (state_q == ST_IDLE || new_instr) begin
      cf_valid = req;
      if (req) state_d = cf_ack ? ST_DONE : ST_REQ;
      else     state_d = ST_IDLE;
    end
  end

  // an ack racing a new instruction in REQ belongs to the abandoned request
  assign ack_hit  = cf_valid & cf_ack & ~((state_q == ST_REQ) & new_instr);
  assign finished = valid & (ack_hit | ((state_q == ST_DONE) & ~new_instr) |
                             trap_raise | (is_cond & ~cond_true));

  // writeback op and next pc
  always_comb begin
    new_op = CFU_OP_NOP;
    new_pc = npc;
    if (valid) begin
      if (trap_raise)          new_op = CFU_OP_TRAP;
      else if (cfu_op[OP_MRET]) new_op = CFU_OP_MRET;
      else if (taken)          new_op = CFU_OP_TAKEN;
      else if (is_cond)        new_op = CFU_OP_IGNORE;
      if (taken && !trap_raise) new_pc = cf_target;
    end
  end

  assign rd_wdata = npc;
  assign rd_wen   = valid & (cfu_op[OP_JAL] | cfu_op[OP_JALR]) & ~trap_raise;

  // call/return classification; equal link rd and rs1 is a plain push
  assign link_rd  = is_link(rd_addr);
  assign link_rs1 = is_link(rs1_addr);
  assign do_push  = (cfu_op[OP_JAL] | cfu_op[OP_JALR]) & link_rd;
  assign do_pop   = cfu_op[OP_JALR] & link_rs1 & ~(link_rd & (rd_addr == rs1_addr));

  // one RAS update per instruction, on its first clean finish
  assign commit = finished & ~trap_raise & (armed_q | new_instr) & ~g_reset;

  assign ras_pred_valid = valid & do_pop & ~ras_empty;
  assign ras_mispredict = commit & do_pop & ras_pred_valid & (ras_pred_target != target);

  // FSM state, held request target and commit arming
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      armed_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q != ST_REQ && state_d == ST_REQ) target_q <= dest;
      if (commit)         armed_q <= 1'b0;
      else if (new_instr) armed_q <= 1'b1;
    end
  end

  core_cfu_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .push      (commit & do_push),
    .pop       (commit & do_pop),
    .push_data (npc),
    .top       (ras_pred_target),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_core_pipe_exec_cfu_ras.sv
// Directed bench for the execute-stage control flow unit with RAS.
module tb_core_pipe_exec_cfu_ras;
  import core_cfu_pkg::*;

  localparam int XLEN = 64;

  logic                g_clk = 1'b0;
  logic                g_reset = 1'b1;
  logic                new_instr = 1'b0;
  logic                valid = 1'b0;
  logic [XLEN-1:0]     pc = '0, npc = '0, rs1 = '0, offset = '0, csr_mepc = '0;
  logic [4:0]          rd_addr = '0, rs1_addr = '0;
  logic                cmp_eq = 1'b0, cmp_lt = 1'b0, cmp_ltu = 1'b0;
  logic [CFU_OP_N-1:0] cfu_op = '0;
  logic                cf_ack = 1'b0;
  logic                cf_valid, rd_wen, trap_raise, finished;
  logic                ras_pred_valid, ras_mispredict;
  logic [XLEN-1:0]     cf_target, new_pc, rd_wdata, ras_pred_target;
  logic [CFU_OP_W-1:0] new_op;
  logic [6:0]          trap_cause;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 g_clk = ~g_clk;

  core_pipe_exec_cfu_ras #(
    .XLEN(XLEN), .PADDR_W(39), .IALIGN(4), .RAS_DEPTH(4)
  ) dut (
    .g_clk(g_clk), .g_reset(g_reset), .new_instr(new_instr), .valid(valid),
    .pc(pc), .npc(npc), .rs1(rs1), .offset(offset),
    .rd_addr(rd_addr), .rs1_addr(rs1_addr),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
    .cfu_op(cfu_op), .csr_mepc(csr_mepc),
    .cf_valid(cf_valid), .cf_ack(cf_ack), .cf_target(cf_target),
    .new_pc(new_pc), .new_op(new_op), .rd_wdata(rd_wdata), .rd_wen(rd_wen),
    .trap_raise(trap_raise), .trap_cause(trap_cause), .finished(finished),
    .ras_pred_valid(ras_pred_valid), .ras_pred_target(ras_pred_target),
    .ras_mispredict(ras_mispredict)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int op_idx, input logic [63:0] pc_v, input logic [63:0] npc_v,
                       input logic [63:0] rs1_v, input logic [63:0] off_v,
                       input logic [4:0] rd_v, input logic [4:0] rs1a_v, input logic eq_v);
    cfu_op         = '0;
    cfu_op[op_idx] = 1'b1;
    pc = pc_v; npc = npc_v; rs1 = rs1_v; offset = off_v;
    rd_addr = rd_v; rs1_addr = rs1a_v;
    cmp_eq = eq_v; cmp_lt = 1'b0; cmp_ltu = 1'b0;
    valid = 1'b1; new_instr = 1'b1;
  endtask

  task automatic tick;
    @(posedge g_clk);
    #1;
    new_instr = 1'b0;
  endtask

  task automatic mid;
    @(negedge g_clk);
  endtask

  // call with immediate acceptance; pushes npc_v
  task automatic call(input logic [63:0] npc_v);
    drive(OP_JAL, npc_v - 64'h4, npc_v, 64'h0, 64'h100, 5'd1, 5'd0, 1'b0);
    cf_ack = 1'b1;
    mid();
    tick();
    cf_ack = 1'b0;
  endtask

  // return through x1 with immediate acceptance; caller checks at mid-cycle then calls fin
  task automatic ret(input logic [63:0] rs1_v);
    drive(OP_JALR, 64'h800, 64'h804, rs1_v, 64'h0, 5'd0, 5'd1, 1'b0);
    cf_ack = 1'b1;
    mid();
  endtask

  task automatic fin;
    tick();
    cf_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    g_reset = 1'b0;
    mid();
    chk("rst_cf_valid", cf_valid, 0);
    chk("rst_finished", finished, 0);
    chk("rst_trap", trap_raise, 0);
    chk("rst_rd_wen", rd_wen, 0);
    chk("rst_ras_pv", ras_pred_valid, 0);
    chk("rst_ras_mp", ras_mispredict, 0);
    tick();

    // beq taken, ack after 3 waiting cycles, pc changes while waiting
    drive(OP_BEQ, 64'h1000, 64'h1004, 64'h0, 64'h20, 5'd0, 5'd0, 1'b1);
    mid();
    chk("beq_c0_valid", cf_valid, 1);
    chk("beq_c0_target", cf_target, 64'h1020);
    chk("beq_c0_fin", finished, 0);
    chk("beq_c0_op", new_op, CFU_OP_TAKEN);
    tick();
    pc = 64'h9000;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("beq_wait_valid", cf_valid, 1);
      chk("beq_wait_target", cf_target, 64'h1020);
      chk("beq_wait_fin", finished, 0);
      tick();
    end
    cf_ack = 1'b1;
    mid();
    chk("beq_ack_valid", cf_valid, 1);
    chk("beq_ack_target", cf_target, 64'h1020);
    chk("beq_ack_fin", finished, 1);
    chk("beq_ack_newpc", new_pc, 64'h1020);
    tick();
    cf_ack = 1'b0;
    mid();
    chk("beq_done_valid", cf_valid, 0);
    chk("beq_done_fin", finished, 1);
    tick();

    // jal to a halfword-aligned target traps with IALIGN=4
    drive(OP_JAL, 64'h1000, 64'h1004, 64'h0, 64'h2, 5'd1, 5'd0, 1'b0);
    mid();
    chk("jal_mis_trap", trap_raise, 1);
    chk("jal_mis_cause", trap_cause, TRAP_IALIGN);
    chk("jal_mis_rdwen", rd_wen, 0);
    chk("jal_mis_cfv", cf_valid, 0);
    chk("jal_mis_fin", finished, 1);
    chk("jal_mis_op", new_op, CFU_OP_TRAP);
    tick();

    // jalr above the physical address range
    drive(OP_JALR, 64'h2000, 64'h2004, 64'h80_0000_0000, 64'h0, 5'd0, 5'd2, 1'b0);
    mid();
    chk("jalr_pa_trap", trap_raise, 1);
    chk("jalr_pa_cause", trap_cause, TRAP_IACCESS);
    chk("jalr_pa_cfv", cf_valid, 0);
    tick();

    drive(OP_ECALL, 64'h3000, 64'h3004, 64'h0, 64'h0, 5'd0, 5'd0, 1'b0);
    mid();
    chk("ecall_cause", trap_cause, TRAP_ECALLM);
    chk("ecall_cfv", cf_valid, 0);
    tick();

    // return with empty stack: the trapped jal must not have pushed
    ret(64'h300);
    chk("ret_empty_pv", ras_pred_valid, 0);
    chk("ret_empty_mp", ras_mispredict, 0);
    chk("ret_empty_fin", finished, 1);
    fin();

    // call then correctly predicted return
    drive(OP_JAL, 64'h100, 64'h104, 64'h0, 64'h40, 5'd1, 5'd0, 1'b0);
    cf_ack = 1'b1;
    mid();
    chk("call_rdwen", rd_wen, 1);
    chk("call_rdwdata", rd_wdata, 64'h104);
    chk("call_target", cf_target, 64'h140);
    fin();
    ret(64'h104);
    chk("ret_ok_pv", ras_pred_valid, 1);
    chk("ret_ok_pt", ras_pred_target, 64'h104);
    chk("ret_ok_mp", ras_mispredict, 0);
    chk("ret_ok_target", cf_target, 64'h104);
    fin();

    // call then mispredicted return: single pulse
    call(64'h104);
    ret(64'h200);
    chk("ret_bad_pv", ras_pred_valid, 1);
    chk("ret_bad_mp", ras_mispredict, 1);
    fin();
    mid();
    chk("ret_bad_mp_next", ras_mispredict, 0);
    tick();

    // overflow: five pushes into four entries, then five pops
    for (int i = 1; i <= 5; i++) call(64'(i * 16));
    for (int k = 0; k < 4; k++) begin
      ret(64'h1000);
      chk("ovf_pv", ras_pred_valid, 1);
      chk("ovf_pt", ras_pred_target, 64'h50 - 64'(k * 16));
      fin();
    end
    ret(64'h1000);
    chk("ovf_last_pv", ras_pred_valid, 0);
    fin();

    // reset while a request is outstanding, with an ack in the same cycle
    drive(OP_JAL, 64'h500, 64'h504, 64'h0, 64'h40, 5'd1, 5'd0, 1'b0);
    mid();
    chk("rq_c0_valid", cf_valid, 1);
    tick();
    mid();
    chk("rq_req_valid", cf_valid, 1);
    chk("rq_req_target", cf_target, 64'h540);
    g_reset = 1'b1;
    cf_ack  = 1'b1;
    tick();
    g_reset = 1'b0;
    cf_ack  = 1'b0;
    valid   = 1'b0;
    mid();
    chk("rq_after_valid", cf_valid, 0);
    chk("rq_after_fin", finished, 0);
    tick();

    drive(OP_BNE, 64'h600, 64'h604, 64'h0, 64'h80, 5'd0, 5'd0, 1'b1);
    mid();
    chk("bne_nt_fin", finished, 1);
    chk("bne_nt_op", new_op, CFU_OP_IGNORE);
    chk("bne_nt_cfv", cf_valid, 0);
    chk("bne_nt_newpc", new_pc, 64'h604);
    tick();
    mid();
    chk("bne_nt_cfv2", cf_valid, 0);
    tick();

    ret(64'h1000);
    chk("rq_ras_empty", ras_pred_valid, 0);
    fin();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_pipe_exec_cfu_ras.md
Name: core_pipe_exec_cfu_ras

Overview:
- Parametrised next-generation execute-stage control flow unit.
- Resolves conditional branches, jumps, mret, ecall and ebreak.
- Drives the control-flow-change bus through an explicit request FSM.
- Adds a configurable instruction-alignment mode and a return-address stack (RAS) that predicts jalr return targets and flags mispredictions for performance counters.
- Sits between decode/operand fetch and writeback in the core pipeline.

Parameters:
- XLEN, 64, register and address width.
- PADDR_W, 39, implemented physical address bits. A set bit in target[XLEN-1:PADDR_W] means non-existent; the check is disabled when PADDR_W == XLEN.
- IALIGN, 2, required target alignment in bytes: 2 (C extension) or 4.
- RAS_DEPTH, 4, RAS entries, power of two, >= 2.

Ports:
- g_clk  in  1  clock
- g_reset  in  1  synchronous active-high reset
- new_instr  in  1  a new instruction enters this stage this cycle
- valid  in  1  operands valid
- pc, npc, rs1, offset  in  XLEN each  current PC, next natural PC, rs1 value, immediate
- rd_addr, rs1_addr  in  5 each  register indices, used for link detection
- cmp_eq, cmp_lt, cmp_ltu  in  1 each  comparator results
- cfu_op  in  12  one-hot: beq, bne, blt, bge, bltu, bgeu, j, jal, jalr, mret, ebrk, ecall
- csr_mepc  in  XLEN  mret target
- cf_valid  out  1  control-flow change request
- cf_ack  in  1  request accepted
- cf_target  out  XLEN  destination
- new_pc  out  XLEN  next PC
- new_op  out  CFU_OP_W  writeback op: TRAP, MRET, TAKEN, IGNORE, NOP
- rd_wdata  out  XLEN  link value (npc)
- rd_wen  out  1  link writeback enable
- trap_raise  out  1  trap raised
- trap_cause  out  7  trap cause
- finished  out  1  instruction complete
- ras_pred_valid  out  1  RAS non-empty and current op is a return
- ras_pred_target  out  XLEN  RAS top-of-stack value
- ras_mispredict  out  1  one-cycle pulse at completion of a mispredicted return

Behaviour:
- Reset values: cf_valid, finished, trap_raise, rd_wen, ras_* all 0. FSM in IDLE. RAS count 0, pointer 0.
- Target:
  - jalr: (rs1 + offset) with bit 0 cleared.
  - Other ops: pc + offset.
  - Result is modulo 2^XLEN.
- Misaligned:
  - IALIGN=2: target[0] (never set for jalr).
  - IALIGN=4: |target[1:0].
- Trap priority: non-existent -> IACCESS; then ecall -> ECALLM; then ebrk -> BREAKPT; else IALIGN.
  - Misaligned and non-existent traps apply only to taken transfers.
  - A trap suppresses rd_wen, cf_valid and RAS update.
- Taken and new_pc/new_op rules are unchanged from the current CFU.
  - cf_target = csr_mepc for mret, otherwise the computed target.
- Request FSM:
  - IDLE -> REQ when valid & taken & !trap. cf_valid asserts combinationally in IDLE and is held through REQ.
  - REQ -> DONE on cf_ack. If ack arrives in the first cycle, go IDLE -> DONE directly.
  - DONE -> IDLE on new_instr.
  - cf_target must remain stable while cf_valid=1 and ack=0.
  - cf_valid is never asserted in DONE.
- finished = (cf_valid & cf_ack) | DONE | trap_raise | not-taken conditional, gated by valid.
- RAS: link register = x1 or x5.
  - push: jal/jalr with link rd.
  - pop: jalr with link rs1 and non-link rd.
  - pop-then-push: both rd and rs1 are link registers and rd != rs1.
  - push only: both are link registers and rd == rs1.
  - Updates commit once per instruction, on the first cycle finished=1 with no trap. new_instr re-arms the commit.
- RAS overflow: push at full overwrites the oldest entry (circular pointer, count saturates at RAS_DEPTH).
- RAS underflow: pop when empty leaves it empty; ras_pred_valid=0.
- ras_mispredict pulses for a popping jalr when ras_pred_valid=1 and ras_pred_target != target, in the same cycle as the commit.
- new_instr in the same cycle as cf_ack: new_instr wins, and the FSM goes to IDLE.
- Reset asserted mid-REQ: cf_valid drops the next cycle; no RAS commit.

Decomposition:
- Shared package core_cfu_pkg:
  - CFU_OP_* encodings and CFU_OP_W.
  - TRAP_* cause codes.
  - cfu_op one-hot bit indices.
  - Link-register index constants.
- One sub-module: core_cfu_ras, the circular stack containing push/pop/pop-push logic, count and top-of-stack output.

Test Plan:
- beq, cmp_eq=1, pc=0x1000, offset=0x20, cf_ack delayed 3 cycles -> cf_valid held 4 cycles, cf_target=0x1020 stable, finished on the ack cycle, new_op=TAKEN.
- IALIGN=4, jal pc=0x1000, offset=0x2 -> trap_raise=1, cause=IALIGN, rd_wen=0, cf_valid=0, RAS count unchanged.
- PADDR_W=39, jalr rs1=0x80_0000_0000 -> cause=IACCESS, no request.
- jal rd=x1 at npc=0x104, then jalr rd=x0, rs1=x1, target 0x104 -> ras_pred_valid=1, ras_pred_target=0x104, ras_mispredict=0. Repeat with target 0x200 -> mispredict pulses once.
- RAS_DEPTH=4: 5 pushes (0x10..0x50), then 5 pops -> predictions 0x50, 0x40, 0x30, 0x20, then ras_pred_valid=0.
- g_reset asserted while in REQ -> cf_valid=0 the next cycle, FSM in IDLE, RAS empty. A following bne with not-taken condition -> finished=1, new_op=IGNORE, cf_valid never asserted.
